// File: rtl/first_nios2_system_pkg.sv
// Shared definitions for the first_nios2_system slice: arbiter state encoding and
// the system-ID constant returned by the sysid slave.
package first_nios2_system_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } arb_state_e;

  localparam logic [31:0] SYSID_ID_VALUE = 32'h5A8F03B3;
  localparam int unsigned LAT_CNT_W      = 4;
  localparam int unsigned LAT_CNT_MAX    = (1 << LAT_CNT_W) - 1;

endpackage

// File: rtl/first_nios2_system_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the master
// that did not own the previous transaction.
module first_nios2_system_rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       any
);

  assign any    = |req;
  assign winner = (&req) ? ~last : req[1];

endmodule

// File: rtl/first_nios2_system_sysid_arbiter.sv
// Two-master read arbiter in front of the zero-wait system-ID slave: round-robin
// grant, waitrequest stall, registered slave strobe/address and read data.
module first_nios2_system_sysid_arbiter
  import first_nios2_system_pkg::*;
#(
  parameter int unsigned ADDR_W = 1,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  input  logic [DATA_W-1:0] s_readdata,
  output logic              grant_idx
);

  if (RD_LAT > LAT_CNT_MAX) begin : g_bad_rd_lat
    $error("RD_LAT must fit the 4-bit latency counter (0..15)");
  end

  localparam logic [LAT_CNT_W-1:0] RD_LAT_CNT = LAT_CNT_W'(RD_LAT);

  arb_state_e           state_q, state_d;
  logic [LAT_CNT_W-1:0] lat_cnt_q;
  logic                 last_grant_q;
  logic [DATA_W-1:0]    rdata_q;
  logic                 pick_winner;
  logic                 pick_any;

  first_nios2_system_rr_pick2 u_pick (
    .req    ({m1_read, m0_read}),
    .last   (last_grant_q),
    .winner (pick_winner),
    .any    (pick_any)
  );

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: state_d is defaulted first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pick_any) state_d = ST_ISSUE;
      ST_ISSUE: if (lat_cnt_q == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s_address    <= '0;
      s_read       <= 1'b0;
      grant_idx    <= 1'b0;
      last_grant_q <= 1'b1;
      lat_cnt_q    <= '0;
      rdata_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            // Address is captured only here; later changes by the master are ignored.
            s_address <= pick_winner ? m1_address : m0_address;
            grant_idx <= pick_winner;
            s_read    <= 1'b1;
            lat_cnt_q <= RD_LAT_CNT;
          end
        end
        ST_ISSUE: begin
          if (lat_cnt_q == '0) begin
            rdata_q <= s_readdata;
            s_read  <= 1'b0;
          end else begin
            lat_cnt_q <= lat_cnt_q - 1'b1;
          end
        end
        ST_DONE: last_grant_q <= grant_idx;
        default: ;
      endcase
    end
  end

  // A master that dropped read mid-transaction simply never sees its response.
  assign m0_waitrequest = m0_read & ~((state_q == ST_DONE) & (grant_idx == 1'b0));
  assign m1_waitrequest = m1_read & ~((state_q == ST_DONE) & (grant_idx == 1'b1));
  assign m0_readdata    = rdata_q;
  assign m1_readdata    = rdata_q;

endmodule

// File: tb/tb_first_nios2_system_sysid_arbiter.sv
// Directed bench for the sysid arbiter: one instance with RD_LAT=0 and one with
// RD_LAT=3, each in front of a combinational sysid slave model.
module tb_first_nios2_system_sysid_arbiter;
  import first_nios2_system_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  // RD_LAT = 0 instance
  logic        m0_address = 1'b0, m0_read = 1'b0, m0_waitrequest;
  logic        m1_address = 1'b0, m1_read = 1'b0, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata, s_readdata;
  logic        s_address, s_read, grant_idx;

  // RD_LAT = 3 instance
  logic        l_m0_address = 1'b0, l_m0_read = 1'b0, l_m0_waitrequest;
  logic        l_m1_address = 1'b0, l_m1_read = 1'b0, l_m1_waitrequest;
  logic [31:0] l_m0_readdata, l_m1_readdata, l_s_readdata;
  logic        l_s_address, l_s_read, l_grant_idx;

  always #5 clock = ~clock;

  assign s_readdata   = s_address   ? SYSID_ID_VALUE : 32'h0;
  assign l_s_readdata = l_s_address ? SYSID_ID_VALUE : 32'h0;

  first_nios2_system_sysid_arbiter #(.ADDR_W(1), .DATA_W(32), .RD_LAT(0)) dut (
    .clock(clock), .reset_n(reset_n),
    .m0_address(m0_address), .m0_read(m0_read),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m1_address(m1_address), .m1_read(m1_read),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .s_address(s_address), .s_read(s_read), .s_readdata(s_readdata),
    .grant_idx(grant_idx)
  );

  first_nios2_system_sysid_arbiter #(.ADDR_W(1), .DATA_W(32), .RD_LAT(3)) dut_lat (
    .clock(clock), .reset_n(reset_n),
    .m0_address(l_m0_address), .m0_read(l_m0_read),
    .m0_waitrequest(l_m0_waitrequest), .m0_readdata(l_m0_readdata),
    .m1_address(l_m1_address), .m1_read(l_m1_read),
    .m1_waitrequest(l_m1_waitrequest), .m1_readdata(l_m1_readdata),
    .s_address(l_s_address), .s_read(l_s_read), .s_readdata(l_s_readdata),
    .grant_idx(l_grant_idx)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Wait (bounded) for the given master's waitrequest to drop; cycles = -1 on timeout.
  task automatic wait_done(input logic which, output int cycles);
    cycles = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if ((which ? m1_waitrequest : m0_waitrequest) == 1'b0) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int got;

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_s_read", s_read, 0);
    check("rst_s_address", s_address, 0);
    check("rst_grant_idx", grant_idx, 0);
    check("rst_readdata", m0_readdata, 32'h0);
    check("rst_m0_wr", m0_waitrequest, 0);
    reset_n = 1'b1;

    // 1) m0 reads addr 1 alone: s_read for one cycle, response at cycle 2
    @(negedge clock);
    m0_address = 1'b1; m0_read = 1'b1;
    #1 check("t1_wr_idle", m0_waitrequest, 1);
    @(negedge clock);
    check("t1_s_read_issue", s_read, 1);
    check("t1_s_address", s_address, 1);
    check("t1_wr_issue", m0_waitrequest, 1);
    @(negedge clock);
    check("t1_s_read_done", s_read, 0);
    check("t1_wr_done", m0_waitrequest, 0);
    check("t1_rdata", m0_readdata, SYSID_ID_VALUE);
    check("t1_m1_wr", m1_waitrequest, 0);
    m0_read = 1'b0;
    @(negedge clock);

    // 2) simultaneous requests from reset: m0 first, then m1
    do_reset();
    m0_address = 1'b0; m0_read = 1'b1;
    m1_address = 1'b1; m1_read = 1'b1;
    wait_done(1'b0, cyc);
    check("t2_m0_latency", cyc, 2);
    check("t2_m0_grant", grant_idx, 0);
    check("t2_m0_data", m0_readdata, 32'h0);
    check("t2_m1_held", m1_waitrequest, 1);
    m0_read = 1'b0;
    wait_done(1'b1, cyc);
    check("t2_m1_latency", cyc, 3);
    check("t2_m1_grant", grant_idx, 1);
    check("t2_m1_data", m1_readdata, SYSID_ID_VALUE);
    m1_read = 1'b0;
    @(negedge clock);

    // 3) both hold read: grants alternate 0,1,0,1,0,1
    do_reset();
    m0_address = 1'b1; m0_read = 1'b1;
    m1_address = 1'b0; m1_read = 1'b1;
    for (int t = 0; t < 6; t++) begin
      got = -1;
      for (int i = 0; i < 10; i++) begin
        @(negedge clock);
        if (!m0_waitrequest || !m1_waitrequest) begin
          got = int'(grant_idx);
          break;
        end
      end
      check($sformatf("t3_grant_%0d", t), got, t % 2);
      check($sformatf("t3_data_%0d", t), m0_readdata, (t % 2) ? 32'h0 : SYSID_ID_VALUE);
      check($sformatf("t3_other_held_%0d", t), (t % 2) ? m0_waitrequest : m1_waitrequest, 1);
    end
    m0_read = 1'b0; m1_read = 1'b0;
    @(negedge clock);

    // 4) RD_LAT=3: response 5 cycles after request; address change ignored
    l_m0_address = 1'b1; l_m0_read = 1'b1;
    cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (i == 1) l_m0_address = 1'b0;
      if (!l_m0_waitrequest) begin
        cyc = i;
        break;
      end
    end
    check("t4_latency", cyc, 5);
    check("t4_data", l_m0_readdata, SYSID_ID_VALUE);
    @(negedge clock);
    check("t4_single_cycle", l_m0_waitrequest, 1);
    l_m0_read = 1'b0;
    @(negedge clock);

    // 5) reset during ISSUE, then a clean read
    m1_address = 1'b1; m1_read = 1'b1;
    @(negedge clock);
    check("t5_issue", s_read, 1);
    reset_n = 1'b0;
    #1;
    check("t5_rst_s_read", s_read, 0);
    check("t5_rst_wr", m1_waitrequest, 1);
    check("t5_rst_rdata", m1_readdata, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    wait_done(1'b1, cyc);
    check("t5_latency", cyc, 2);
    check("t5_data", m1_readdata, SYSID_ID_VALUE);
    m1_read = 1'b0;
    @(negedge clock);

    // 6) m1 drops read during ISSUE; pending m0 served next
    m0_address = 1'b0; m0_read = 1'b1;
    m1_address = 1'b1; m1_read = 1'b1;
    wait_done(1'b0, cyc);
    check("t6_m0_first", grant_idx, 0);
    repeat (2) @(negedge clock);
    check("t6_m1_issue_grant", grant_idx, 1);
    check("t6_m1_issue_s_read", s_read, 1);
    m1_read = 1'b0;
    @(negedge clock);
    check("t6_m0_still_held", m0_waitrequest, 1);
    wait_done(1'b0, cyc);
    check("t6_m0_latency", cyc, 3);
    check("t6_m0_grant", grant_idx, 0);
    check("t6_m0_data", m0_readdata, 32'h0);
    m0_read = 1'b0;
    @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
